sram_controller_banked: RTL and testbench
=========================================

# sram_controller_banked

Parametrised Wishbone-classic slave driving one or more asynchronous SRAM chips on a shared address/data/strobe bus, with one chip-enable per bank. It is the next-generation SRAM controller between the Wishbone arbiter and the board SRAMs. Read wait states and write setup/pulse/hold phases are set per instance, so one RTL serves different SRAM speed grades. Addresses that decode to a non-existent bank terminate with `wb_err_o` and perform no SRAM cycle.

## Interface
Parameters:
- `DATA_WIDTH`, 32: Wishbone data width; equals `SRAM_DATA_WIDTH`.
- `ADDR_WIDTH`, 32: Wishbone byte-address width.
- `SRAM_ADDR_WIDTH`, 20: word-address width per bank.
- `SRAM_DATA_WIDTH`, 32: SRAM data width; multiple of 8.
- `NUM_BANKS`, 2: number of SRAM chips, 1..4.
- `READ_WAIT`, 2: cycles `oe_n` is held low before data is sampled, ≥1.
- `WRITE_SETUP`, 1: cycles of address/data valid before `we_n` falls, ≥1.
- `WRITE_PULSE`, 1: cycles `we_n` is low, ≥1.
- `WRITE_HOLD`, 1: cycles of address/data held after `we_n` rises, ≥1.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i` in 1: Wishbone request.
- `wb_adr_i` in `ADDR_WIDTH`: byte address.
- `wb_dat_i` in `DATA_WIDTH`: write data.
- `wb_sel_i` in `DATA_WIDTH/8`: byte lane selects.
- `wb_dat_o` out `DATA_WIDTH`: registered read data.
- `wb_ack_o` out 1: normal termination, one-cycle pulse.
- `wb_err_o` out 1: error termination, one-cycle pulse.
- `sram_addr` out `SRAM_ADDR_WIDTH`: shared word address.
- `sram_data` inout `SRAM_DATA_WIDTH`: shared data bus.
- `sram_ce_n` out `NUM_BANKS`: per-bank chip enable, active-low.
- `sram_oe_n`, `sram_we_n` out 1: shared, active-low.
- `sram_be_n` out `SRAM_DATA_WIDTH/8`: byte enables, active-low.

## Operation
Address decode:
- Word address = `wb_adr_i[SRAM_ADDR_WIDTH+1:2]`.
- Bank index = `wb_adr_i[SRAM_ADDR_WIDTH+2 +: max(1,$clog2(NUM_BANKS))]`.
- Index ≥ `NUM_BANKS` → error. Higher address bits are ignored.

FSM states are IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, TERM.

- IDLE, `cyc&stb` sampled:
  - Bad bank → TERM with `wb_err_o` set.
  - Read → `sram_addr`, `be_n=~sel`, `ce_n[bank]=0`, `oe_n=0`, bus released → RD_WAIT.
  - Write → same address and enable setup with `oe_n=1`, bus driven with `wb_dat_i` → WR_SETUP.
- RD_WAIT, `READ_WAIT` cycles:
  - On the last cycle, latch `sram_data` into `wb_dat_o`, with unselected byte lanes forced to 0.
  - Deassert `ce_n`/`oe_n` and set `wb_ack_o` → TERM.
- WR_SETUP (`WRITE_SETUP` cycles) → WR_PULSE.
- WR_PULSE: `we_n=0` for `WRITE_PULSE` cycles → WR_HOLD.
- WR_HOLD: `we_n=1` with address, data and `ce_n` held for `WRITE_HOLD` cycles. Then deassert `ce_n` and set `wb_ack_o` → TERM.
- TERM: clear ack/err, release data bus, all `ce_n` high → IDLE.
- A single phase counter, loaded on each state entry, times every multi-cycle state.
- Dropping `cyc`/`stb` mid-access does not abort it. The SRAM cycle completes and ack still pulses.
- At most one bank's `ce_n` is low at any time. `oe_n` and `we_n` are never both low.

## Timing
Reset values (any edge with `rst_ni=0`, also mid-access):
- `wb_ack_o=0`, `wb_err_o=0`, `wb_dat_o=0`.
- All `sram_ce_n=1`, `sram_oe_n=1`, `sram_we_n=1`, `sram_be_n` all 1, `sram_addr=0`.
- Data bus high-Z, state IDLE.
- An interrupted access gets no ack.

Latency, with the request sampled at edge 0:
- Read ack is high in cycle `READ_WAIT+1` (default 3).
- Write ack is high in cycle `WRITE_SETUP+WRITE_PULSE+WRITE_HOLD+1` (default 4).
- Err is high in cycle 1.

Handshake:
- Ack/err is high for exactly one cycle, then TERM forces one idle cycle.
- A held `stb` after ack is not re-accepted until IDLE, so the minimum request spacing is latency+1.
- The data bus is driven only in WR_SETUP, WR_PULSE and WR_HOLD, so there is one-cycle turnaround before any read.

## Structure
- Package `sram_ctrl_pkg` holds:
  - the state enum `sram_state_t`;
  - the default timing constants;
  - the function `bank_bits(n)`.
- One sub-module, `sram_phase_counter`: a loadable down-counter with a `done` flag, width `$clog2(max timing param+1)`.

## Test plan
- Reset and idle: hold `rst_ni=0` for 3 cycles → all outputs at reset values, bus high-Z.
- Write then read, bank 0:
  - Write 0xDEADBEEF at 0x0000_0010 with sel 0xF → `we_n` low exactly in cycle 2, ack in cycle 4.
  - Read back the same address → `wb_dat_o`=0xDEADBEEF, ack in cycle 3.
- Bank 1 with partial byte select:
  - Write 0x11223344 at 0x0040_0020 with sel 0x3 → `ce_n`=2'b01, `be_n`=4'b1100.
  - Read with sel 0x3 → `wb_dat_o`=0x00003344.
- Invalid bank: with `NUM_BANKS=3`, access 0x00C0_0000 → err in cycle 1, no `ce_n` asserted, ack stays 0.
- Reconfigured timing: `READ_WAIT=4`, `WRITE_PULSE=3` → read ack in cycle 5, `we_n` low for 3 cycles, ack in cycle 6.
- Reset mid-write: assert `rst_ni=0` during WR_PULSE → next cycle `we_n=1`, `ce_n` all 1, bus high-Z, no ack ever.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types, default timing and helpers for the banked SRAM controller.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        TERM
    } sram_state_t;

    localparam int unsigned DEF_READ_WAIT   = 2;
    localparam int unsigned DEF_WRITE_SETUP = 1;
    localparam int unsigned DEF_WRITE_PULSE = 1;
    localparam int unsigned DEF_WRITE_HOLD  = 1;

    // A single bank still gets one decode bit so index 1 maps to an error.
    function automatic int unsigned bank_bits(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Loadable down-counter timing the multi-cycle controller phases.
module sram_phase_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             done_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/sram_controller_banked.sv
// Wishbone-classic slave for banked asynchronous SRAM with per-instance timing.
module sram_controller_banked
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned SRAM_ADDR_WIDTH = 20,
    parameter int unsigned SRAM_DATA_WIDTH = 32,
    parameter int unsigned NUM_BANKS       = 2,
    parameter int unsigned READ_WAIT       = DEF_READ_WAIT,
    parameter int unsigned WRITE_SETUP     = DEF_WRITE_SETUP,
    parameter int unsigned WRITE_PULSE     = DEF_WRITE_PULSE,
    parameter int unsigned WRITE_HOLD      = DEF_WRITE_HOLD
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         wb_cyc_i,
    input  logic                         wb_stb_i,
    input  logic                         wb_we_i,
    input  logic [ADDR_WIDTH-1:0]        wb_adr_i,
    input  logic [DATA_WIDTH-1:0]        wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0]      wb_sel_i,
    output logic [DATA_WIDTH-1:0]        wb_dat_o,
    output logic                         wb_ack_o,
    output logic                         wb_err_o,
    output logic [SRAM_ADDR_WIDTH-1:0]   sram_addr,
    inout  wire  [SRAM_DATA_WIDTH-1:0]   sram_data,
    output logic [NUM_BANKS-1:0]         sram_ce_n,
    output logic                         sram_oe_n,
    output logic                         sram_we_n,
    output logic [SRAM_DATA_WIDTH/8-1:0] sram_be_n
);

    localparam int unsigned BANK_BITS = bank_bits(NUM_BANKS);
    localparam int unsigned MAX_T     = max_u(max_u(READ_WAIT, WRITE_SETUP),
                                              max_u(WRITE_PULSE, WRITE_HOLD));
    localparam int unsigned CNT_W     = $clog2(MAX_T + 1);
    localparam int unsigned NBYTES    = SRAM_DATA_WIDTH / 8;

    sram_state_t                state_q, state_d;
    logic                       ack_q, ack_d, err_q, err_d;
    logic [DATA_WIDTH-1:0]      rdat_q, rdat_d;
    logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NUM_BANKS-1:0]       ce_n_q, ce_n_d;
    logic                       oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic [NBYTES-1:0]          be_n_q, be_n_d;
    logic                       drive_q, drive_d;
    logic [SRAM_DATA_WIDTH-1:0] wdat_q, wdat_d;

    logic                       cnt_load, cnt_done;
    logic [CNT_W-1:0]           cnt_val;
    logic [BANK_BITS-1:0]       bank;
    logic                       bank_ok;
    logic [SRAM_DATA_WIDTH-1:0] rmask;
    logic                       unused_adr;

    assign bank       = wb_adr_i[SRAM_ADDR_WIDTH+2 +: BANK_BITS];
    assign bank_ok    = (32'(bank) < NUM_BANKS);
    assign unused_adr = ^wb_adr_i;

    sram_phase_counter #(
        .WIDTH(CNT_W)
    ) u_phase_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (cnt_load),
        .load_val_i(cnt_val),
        .done_o    (cnt_done)
    );

    always_comb begin
        rmask = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            rmask[i*8 +: 8] = {8{~be_n_q[i]}};
        end
    end

    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rdat_d   = rdat_q;
        addr_d   = addr_q;
        ce_n_d   = ce_n_q;
        oe_n_d   = oe_n_q;
        we_n_d   = we_n_q;
        be_n_d   = be_n_q;
        drive_d  = drive_q;
        wdat_d   = wdat_q;
        cnt_load = 1'b0;
        cnt_val  = '0;

        unique case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    if (!bank_ok) begin
                        err_d   = 1'b1;
                        state_d = TERM;
                    end else begin
                        addr_d = wb_adr_i[SRAM_ADDR_WIDTH+1:2];
                        be_n_d = ~wb_sel_i;
                        ce_n_d = '1;
                        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                            if (bank == BANK_BITS'(b)) ce_n_d[b] = 1'b0;
                        end
                        cnt_load = 1'b1;
                        if (wb_we_i) begin
                            oe_n_d  = 1'b1;
                            drive_d = 1'b1;
                            wdat_d  = wb_dat_i;
                            cnt_val = CNT_W'(WRITE_SETUP - 1);
                            state_d = WR_SETUP;
                        end else begin
                            oe_n_d  = 1'b0;
                            drive_d = 1'b0;
                            cnt_val = CNT_W'(READ_WAIT - 1);
                            state_d = RD_WAIT;
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_done) begin
                    rdat_d  = sram_data & rmask;
                    ce_n_d  = '1;
                    oe_n_d  = 1'b1;
                    ack_d   = 1'b1;
                    state_d = TERM;
                end
            end
            WR_SETUP: begin
                if (cnt_done) begin
                    we_n_d   = 1'b0;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(WRITE_PULSE - 1);
                    state_d  = WR_PULSE;
                end
            end
            WR_PULSE: begin
                if (cnt_done) begin
                    we_n_d   = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(WRITE_HOLD - 1);
                    state_d  = WR_HOLD;
                end
            end
            WR_HOLD: begin
                // Bus is released together with ce_n so TERM already sees high-Z.
                if (cnt_done) begin
                    ce_n_d  = '1;
                    drive_d = 1'b0;
                    ack_d   = 1'b1;
                    state_d = TERM;
                end
            end
            TERM: begin
                ce_n_d  = '1;
                drive_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
            addr_q  <= '0;
            ce_n_q  <= '1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            be_n_q  <= '1;
            drive_q <= 1'b0;
            wdat_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
            addr_q  <= addr_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            be_n_q  <= be_n_d;
            drive_q <= drive_d;
            wdat_q  <= wdat_d;
        end
    end

    assign wb_ack_o  = ack_q;
    assign wb_err_o  = err_q;
    assign wb_dat_o  = rdat_q;
    assign sram_addr = addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign sram_be_n = be_n_q;
    assign sram_data = drive_q ? wdat_q : 'z;

endmodule

// File: tb/tb_sram_controller_banked.sv
// Scoreboard bench: default instance (2 banks) and a 3-bank slow-timing instance.
module tb_sram_controller_banked;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cyc_a, cyc_b, stb, we;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;

    wire  [31:0] sd_a, sd_b;
    logic [31:0] dat_a, dat_b;
    logic        ack_a, ack_b, err_a, err_b;
    logic [19:0] addr_a, addr_b;
    logic [1:0]  ce_a;
    logic [2:0]  ce_b;
    logic        oe_a, we_a, oe_b, we_b;
    logic [3:0]  be_a, be_b;

    sram_controller_banked u_dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .wb_cyc_i(cyc_a), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
        .wb_dat_i(wdat), .wb_sel_i(sel), .wb_dat_o(dat_a),
        .wb_ack_o(ack_a), .wb_err_o(err_a),
        .sram_addr(addr_a), .sram_data(sd_a), .sram_ce_n(ce_a),
        .sram_oe_n(oe_a), .sram_we_n(we_a), .sram_be_n(be_a)
    );

    sram_controller_banked #(
        .NUM_BANKS  (3),
        .READ_WAIT  (4),
        .WRITE_PULSE(3)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .wb_cyc_i(cyc_b), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
        .wb_dat_i(wdat), .wb_sel_i(sel), .wb_dat_o(dat_b),
        .wb_ack_o(ack_b), .wb_err_o(err_b),
        .sram_addr(addr_b), .sram_data(sd_b), .sram_ce_n(ce_b),
        .sram_oe_n(oe_b), .sram_we_n(we_b), .sram_be_n(be_b)
    );

    // Behavioural SRAM: one sparse array per instance keyed by bank and word.
    logic [31:0] mem_a [int];
    logic [31:0] mem_b [int];
    logic [31:0] rd_a, rd_b;

    function automatic int low_idx(input logic [3:0] ce);
        for (int i = 0; i < 4; i++) if (!ce[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin : rd_mdl
        int ka, kb;
        ka = low_idx({2'b11, ce_a});
        kb = low_idx({1'b1, ce_b});
        rd_a <= (ka >= 0 && mem_a.exists(ka * (1 << 20) + int'(addr_a))) ?
                mem_a[ka * (1 << 20) + int'(addr_a)] : 32'hA5A5_5A5A;
        rd_b <= (kb >= 0 && mem_b.exists(kb * (1 << 20) + int'(addr_b))) ?
                mem_b[kb * (1 << 20) + int'(addr_b)] : 32'hA5A5_5A5A;
    end

    assign sd_a = (ce_a != 2'b11 && !oe_a) ? rd_a : 'z;
    assign sd_b = (ce_b != 3'b111 && !oe_b) ? rd_b : 'z;

    always @(posedge we_a) begin : wr_mdl_a
        int k;
        logic [31:0] v;
        k = low_idx({2'b11, ce_a});
        if (k >= 0) begin
            k = k * (1 << 20) + int'(addr_a);
            v = mem_a.exists(k) ? mem_a[k] : 32'h0;
            for (int i = 0; i < 4; i++) if (!be_a[i]) v[i*8 +: 8] = sd_a[i*8 +: 8];
            mem_a[k] = v;
        end
    end

    always @(posedge we_b) begin : wr_mdl_b
        int k;
        logic [31:0] v;
        k = low_idx({1'b1, ce_b});
        if (k >= 0) begin
            k = k * (1 << 20) + int'(addr_b);
            v = mem_b.exists(k) ? mem_b[k] : 32'h0;
            for (int i = 0; i < 4; i++) if (!be_b[i]) v[i*8 +: 8] = sd_b[i*8 +: 8];
            mem_b[k] = v;
        end
    end

    logic        use_b;
    logic        ack_m, err_m, oe_m, we_m;
    logic [31:0] dat_m, sd_m;
    logic [3:0]  ce_m, be_m;
    always_comb begin
        ack_m = use_b ? ack_b : ack_a;
        err_m = use_b ? err_b : err_a;
        oe_m  = use_b ? oe_b  : oe_a;
        we_m  = use_b ? we_b  : we_a;
        dat_m = use_b ? dat_b : dat_a;
        sd_m  = use_b ? sd_b  : sd_a;
        ce_m  = use_b ? {1'b1, ce_b} : {2'b11, ce_a};
        be_m  = use_b ? be_b  : be_a;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    typedef struct {
        bit          err;
        int          lat;
        logic [31:0] rd;
        bit          is_rd;
        logic [3:0]  ce;
        logic [3:0]  be;
        int          we_first;
        int          we_len;
    } exp_t;
    exp_t sb[$];

    task automatic do_txn(input bit b, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit e_err, input int e_lat,
                          input logic [31:0] e_rd, input logic [3:0] e_ce,
                          input int e_wf, input int e_wl);
        exp_t e, p;
        bit got, viol;
        int lat, wf, wl, nlow;
        logic [3:0] ce1, be1;
        logic a_seen, e_seen;
        logic [31:0] rd;
        e.err = e_err; e.lat = e_lat; e.rd = e_rd; e.is_rd = !w;
        e.ce = e_ce; e.be = ~s; e.we_first = e_wf; e.we_len = e_wl;
        sb.push_back(e);
        @(negedge clk);
        use_b = b;
        cyc_a = !b; cyc_b = b; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        @(posedge clk);
        #1;
        // Request withdrawn right after acceptance: the access must still complete.
        cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0;
        got = 0; viol = 0; lat = 0; wf = -1; wl = 0; ce1 = '1; be1 = '1;
        a_seen = 0; e_seen = 0; rd = '0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            if (c == 1) begin ce1 = ce_m; be1 = be_m; end
            if (!we_m) begin if (wf < 0) wf = c; wl++; end
            nlow = 0;
            for (int i = 0; i < 4; i++) if (!ce_m[i]) nlow++;
            if (nlow > 1 || (!oe_m && !we_m)) viol = 1;
            if (ack_m || err_m) begin
                got = 1; lat = c; a_seen = ack_m; e_seen = err_m; rd = dat_m;
            end
        end
        p = sb.pop_front();
        if (!got) begin
            chk("term_timeout", 0, 1);
        end else begin
            chk("latency", lat, p.lat);
            chk("err", e_seen, p.err);
            chk("ack", a_seen, !p.err);
            chk("ce_n", ce1, p.ce);
            if (!p.err) chk("be_n", be1, p.be);
            chk("we_first", wf, p.we_first);
            chk("we_len", wl, p.we_len);
            chk("excl", viol, 0);
            if (p.is_rd && !p.err) chk("rdata", rd, p.rd);
            @(negedge clk);
            chk("pulse", {ack_m, err_m}, 2'b00);
        end
    endtask

    initial begin
        rst_n = 1'b0; cyc_a = 0; cyc_b = 0; stb = 0; we = 0;
        adr = '0; wdat = '0; sel = '0; use_b = 0;
        repeat (3) @(negedge clk);
        chk("rst_a_ctl", {ack_a, err_a, oe_a, we_a, ce_a, be_a}, {2'b00, 2'b11, 2'b11, 4'hF});
        chk("rst_a_dat", {addr_a, dat_a}, '0);
        chk("rst_a_z", (sd_a === 32'hz), 1);
        chk("rst_b_ctl", {ack_b, err_b, oe_b, we_b, ce_b, be_b}, {2'b00, 2'b11, 3'b111, 4'hF});
        chk("rst_b_z", (sd_b === 32'hz), 1);
        rst_n = 1'b1;
        @(negedge clk);

        do_txn(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 4, '0, 4'b1110, 2, 1);
        do_txn(0, 0, 32'h0000_0010, '0, 4'hF, 0, 3, 32'hDEAD_BEEF, 4'b1110, -1, 0);
        do_txn(0, 1, 32'h0040_0020, 32'h1122_3344, 4'h3, 0, 4, '0, 4'b1101, 2, 1);
        do_txn(0, 0, 32'h0040_0020, '0, 4'h3, 0, 3, 32'h0000_3344, 4'b1101, -1, 0);
        do_txn(0, 0, 32'h0040_0020, '0, 4'hC, 0, 3, 32'h0000_0000, 4'b1101, -1, 0);

        do_txn(1, 0, 32'h00C0_0000, '0, 4'hF, 1, 1, '0, 4'b1111, -1, 0);
        do_txn(1, 1, 32'h0000_0100, 32'hCAFE_F00D, 4'hF, 0, 6, '0, 4'b1110, 2, 3);
        do_txn(1, 0, 32'h0000_0100, '0, 4'hF, 0, 5, 32'hCAFE_F00D, 4'b1110, -1, 0);
        do_txn(1, 1, 32'h0080_0044, 32'h5566_7788, 4'hC, 0, 6, '0, 4'b1011, 2, 3);
        do_txn(1, 0, 32'h0080_0044, '0, 4'hF, 0, 5, 32'h5566_0000, 4'b1011, -1, 0);

        // Reset during the write strobe on the slow instance.
        @(negedge clk);
        use_b = 1;
        cyc_b = 1; stb = 1; we = 1; adr = 32'h0000_0200; wdat = 32'h0BAD_0BAD; sel = 4'hF;
        @(posedge clk);
        #1;
        cyc_b = 0; stb = 0;
        repeat (2) @(negedge clk);
        chk("mid_we_low", we_b, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ctl", {we_b, oe_b, ce_b}, {2'b11, 3'b111});
        chk("mid_rst_z", (sd_b === 32'hz), 1);
        rst_n = 1'b1;
        begin : no_ack
            bit seen;
            seen = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (ack_b || err_b) seen = 1;
            end
            chk("mid_rst_noack", seen, 0);
        end
        do_txn(1, 0, 32'h0080_0044, '0, 4'h3, 0, 5, 32'h0000_0000, 4'b1011, -1, 0);
        do_txn(1, 0, 32'h0000_0100, '0, 4'hF, 0, 5, 32'hCAFE_F00D, 4'b1110, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
